// File: rtl/sprite_pkg.sv
// Shared constants for the sprite engine: command opcodes, edge modes,
// update FSM encoding and an address-width helper.
package sprite_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_MOVE_ABS  = 3'd1;
  localparam logic [2:0] OP_MOVE_REL  = 3'd2;
  localparam logic [2:0] OP_SET_VEL   = 3'd3;
  localparam logic [2:0] OP_SET_COLOR = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;

  localparam logic [1:0] MODE_WRAP   = 2'd0;
  localparam logic [1:0] MODE_CLAMP  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_UPD_CMD = 2'd2,
    ST_UPD_MOT = 2'd3
  } state_t;

  // Smallest w with 2**w >= value.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sprite_edge_step.sv
// One axis of per-frame motion: pos + vel with wrap / clamp / bounce at the
// screen edges. Purely combinational; the caller owns the registers.
module sprite_edge_step
  import sprite_pkg::*;
#(
  parameter int POS_W = 10,
  parameter int VEL_W = 5
) (
  input  logic [POS_W-1:0] pos,
  input  logic [VEL_W-1:0] vel,
  input  logic [POS_W-1:0] max_pos,
  input  logic [1:0]       mode,
  output logic [POS_W-1:0] next_pos,
  output logic [VEL_W-1:0] next_vel,
  output logic             edge_hit
);

  localparam int NW = POS_W + 2;

  logic signed [NW-1:0] sum_s;
  logic signed [NW-1:0] max_s;
  logic [POS_W-1:0]     vel_p_s;
  logic [POS_W-1:0]     sum_p_s;
  logic                 under_s;
  logic                 over_s;

  // Detect edge crossings at full signed width; form the result modulo 2**POS_W
  // (every legal result lies in [0,MAX], so the low bits are exact).
  always_comb begin
    max_s    = {2'b00, max_pos};
    sum_s    = $signed({2'b00, pos}) + $signed({{(NW-VEL_W){vel[VEL_W-1]}}, vel});
    vel_p_s  = {{(POS_W-VEL_W){vel[VEL_W-1]}}, vel};
    sum_p_s  = pos + vel_p_s;
    under_s  = sum_s[NW-1];
    over_s   = !under_s && (sum_s > max_s);
    next_pos = sum_p_s;
    next_vel = vel;
    if (under_s) begin
      case (mode)
        MODE_WRAP:   next_pos = sum_p_s + max_pos + {{(POS_W-1){1'b0}}, 1'b1};
        MODE_BOUNCE: begin
          next_pos = {POS_W{1'b0}} - sum_p_s;
          next_vel = {VEL_W{1'b0}} - vel;
        end
        default: begin
          next_pos = {POS_W{1'b0}};
          next_vel = {VEL_W{1'b0}};
        end
      endcase
    end else if (over_s) begin
      case (mode)
        MODE_WRAP:   next_pos = sum_p_s - max_pos - {{(POS_W-1){1'b0}}, 1'b1};
        MODE_BOUNCE: begin
          next_pos = (max_pos << 1) - sum_p_s;
          next_vel = {VEL_W{1'b0}} - vel;
        end
        default: begin
          next_pos = max_pos;
          next_vel = {VEL_W{1'b0}};
        end
      endcase
    end else begin
      next_pos = sum_p_s;
    end
    edge_hit = under_s | over_s;
  end

endmodule

// File: rtl/sprite_engine.sv
// Single movable sprite: command port applied at frame start, per-frame
// velocity motion, and a 2-stage pixel pipeline against an external mask ROM.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int                 SPR_W       = 16,
  parameter int                 SPR_H       = 16,
  parameter int                 POS_W       = 10,
  parameter int                 COLOR_W     = 3,
  parameter int                 SCREEN_W    = 640,
  parameter int                 SCREEN_H    = 480,
  parameter int                 VEL_W       = 5,
  parameter logic [COLOR_W-1:0] RESET_COLOR = 3'b111
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic [POS_W-1:0]                     iColumnCount,
  input  logic [POS_W-1:0]                     iRowCount,
  input  logic                                 iFrameStart,
  input  logic                                 iEnable,
  input  logic [COLOR_W-1:0]                   iColorBack,
  input  logic [1:0]                           iMode,
  input  logic                                 iCmdValid,
  output logic                                 oCmdReady,
  input  logic [2:0]                           iCmdOp,
  input  logic [POS_W-1:0]                     iCmdX,
  input  logic [POS_W-1:0]                     iCmdY,
  input  logic [COLOR_W-1:0]                   iCmdColor,
  output logic [clog2(SPR_W*SPR_H)-1:0]        oMaskAddr,
  input  logic                                 iMask,
  output logic [COLOR_W-1:0]                   oRGB,
  output logic                                 oHit,
  output logic                                 oEdge,
  output logic [POS_W-1:0]                     oPosX,
  output logic [POS_W-1:0]                     oPosY
);

  localparam int LOG_W = clog2(SPR_W);
  localparam int LOG_H = clog2(SPR_H);
  localparam logic [POS_W-1:0] MAX_X = POS_W'(SCREEN_W - SPR_W);
  localparam logic [POS_W-1:0] MAX_Y = POS_W'(SCREEN_H - SPR_H);

  state_t               state_r, next_state_s;
  logic [POS_W-1:0]     pos_x_r, pos_y_r;
  logic [VEL_W-1:0]     vel_x_r, vel_y_r;
  logic [COLOR_W-1:0]   color_r;
  logic [2:0]           pend_op_r;
  logic [POS_W-1:0]     pend_x_r, pend_y_r;
  logic [COLOR_W-1:0]   pend_color_r;
  logic                 ready_r, edge_r;
  logic [POS_W-1:0]     mot_x_s, mot_y_s;
  logic [VEL_W-1:0]     mot_vx_s, mot_vy_s;
  logic                 edge_x_s, edge_y_s;
  logic [POS_W-1:0]     dx_s, dy_s;
  logic                 inside_s, inside_r, hit_r;
  logic [COLOR_W-1:0]   color_q_r, back_r, rgb_r;

  // Relative move saturated to [0,m] independent of the edge mode.
  function automatic logic [POS_W-1:0] sat_rel(input logic [POS_W-1:0] p,
                                               input logic [POS_W-1:0] d,
                                               input logic [POS_W-1:0] m);
    logic signed [POS_W+1:0] s;
    s = $signed({2'b00, p}) + $signed({{2{d[POS_W-1]}}, d});
    if (s[POS_W+1])                    return {POS_W{1'b0}};
    else if (s > $signed({2'b00, m}))  return m;
    else                               return s[POS_W-1:0];
  endfunction

  sprite_edge_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_step_x (
    .pos(pos_x_r), .vel(vel_x_r), .max_pos(MAX_X), .mode(iMode),
    .next_pos(mot_x_s), .next_vel(mot_vx_s), .edge_hit(edge_x_s)
  );

  sprite_edge_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_step_y (
    .pos(pos_y_r), .vel(vel_y_r), .max_pos(MAX_Y), .mode(iMode),
    .next_pos(mot_y_s), .next_vel(mot_vy_s), .edge_hit(edge_y_s)
  );

  // Update FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; a command takes priority over a simultaneous frame start.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iCmdValid)        next_state_s = ST_PEND;
        else if (iFrameStart) next_state_s = ST_UPD_MOT;
        else                  next_state_s = ST_IDLE;
      end
      ST_PEND: begin
        if (iFrameStart) next_state_s = ST_UPD_CMD;
        else             next_state_s = ST_PEND;
      end
      ST_UPD_CMD: next_state_s = ST_UPD_MOT;
      ST_UPD_MOT: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Command capture, command apply and motion update of the sprite state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pos_x_r      <= {POS_W{1'b0}};
      pos_y_r      <= {POS_W{1'b0}};
      vel_x_r      <= {VEL_W{1'b0}};
      vel_y_r      <= {VEL_W{1'b0}};
      color_r      <= RESET_COLOR;
      pend_op_r    <= OP_NOP;
      pend_x_r     <= {POS_W{1'b0}};
      pend_y_r     <= {POS_W{1'b0}};
      pend_color_r <= {COLOR_W{1'b0}};
      ready_r      <= 1'b1;
      edge_r       <= 1'b0;
    end else begin
      ready_r <= (next_state_s == ST_IDLE);
      edge_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iCmdValid) begin
            pend_op_r    <= iCmdOp;
            pend_x_r     <= iCmdX;
            pend_y_r     <= iCmdY;
            pend_color_r <= iCmdColor;
          end
        end
        ST_UPD_CMD: begin
          case (pend_op_r)
            OP_MOVE_ABS: begin
              pos_x_r <= (pend_x_r > MAX_X) ? MAX_X : pend_x_r;
              pos_y_r <= (pend_y_r > MAX_Y) ? MAX_Y : pend_y_r;
            end
            OP_MOVE_REL: begin
              pos_x_r <= sat_rel(pos_x_r, pend_x_r, MAX_X);
              pos_y_r <= sat_rel(pos_y_r, pend_y_r, MAX_Y);
            end
            OP_SET_VEL: begin
              vel_x_r <= pend_x_r[VEL_W-1:0];
              vel_y_r <= pend_y_r[VEL_W-1:0];
            end
            OP_SET_COLOR: color_r <= pend_color_r;
            OP_STOP: begin
              vel_x_r <= {VEL_W{1'b0}};
              vel_y_r <= {VEL_W{1'b0}};
            end
            default: pend_op_r <= OP_NOP;
          endcase
        end
        ST_UPD_MOT: begin
          pos_x_r <= mot_x_s;
          pos_y_r <= mot_y_s;
          vel_x_r <= mot_vx_s;
          vel_y_r <= mot_vy_s;
          edge_r  <= edge_x_s | edge_y_s;
        end
        default: edge_r <= 1'b0;
      endcase
    end
  end

  // Sprite-relative offsets; unsigned wrap turns left/top misses into large values.
  always_comb begin
    dx_s      = iColumnCount - pos_x_r;
    dy_s      = iRowCount - pos_y_r;
    inside_s  = iEnable && (dx_s < POS_W'(SPR_W)) && (dy_s < POS_W'(SPR_H));
    oMaskAddr = {dy_s[LOG_H-1:0], dx_s[LOG_W-1:0]};
  end

  // Two-stage pixel pipeline aligned with the one-cycle mask ROM read.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inside_r  <= 1'b0;
      color_q_r <= {COLOR_W{1'b0}};
      back_r    <= {COLOR_W{1'b0}};
      rgb_r     <= {COLOR_W{1'b0}};
      hit_r     <= 1'b0;
    end else begin
      inside_r  <= inside_s;
      color_q_r <= color_r;
      back_r    <= iColorBack;
      rgb_r     <= (inside_r && iMask) ? color_q_r : back_r;
      hit_r     <= inside_r && iMask;
    end
  end

  assign oCmdReady = ready_r;
  assign oEdge     = edge_r;
  assign oRGB      = rgb_r;
  assign oHit      = hit_r;
  assign oPosX     = pos_x_r;
  assign oPosY     = pos_y_r;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed self-checking bench for sprite_engine (default parameters).
module tb_sprite_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] col = '0, row = '0;
  logic       frame_start = 1'b0, enable = 1'b0, cmd_valid = 1'b0, mask = 1'b0;
  logic [2:0] back = '0, cmd_op = '0, cmd_color = '0;
  logic [1:0] mode = '0;
  logic [9:0] cmd_x = '0, cmd_y = '0;
  logic [7:0] mask_addr;
  logic [2:0] rgb;
  logic       hit, edge_o, ready;
  logic [9:0] pos_x, pos_y;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;
  int rdy0;

  always #5 clk = ~clk;

  sprite_engine dut (
    .Clock(clk), .Reset(rst_n), .iColumnCount(col), .iRowCount(row),
    .iFrameStart(frame_start), .iEnable(enable), .iColorBack(back), .iMode(mode),
    .iCmdValid(cmd_valid), .oCmdReady(ready), .iCmdOp(cmd_op), .iCmdX(cmd_x),
    .iCmdY(cmd_y), .iCmdColor(cmd_color), .oMaskAddr(mask_addr), .iMask(mask),
    .oRGB(rgb), .oHit(hit), .oEdge(edge_o), .oPosX(pos_x), .oPosY(pos_y)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [9:0] x, input logic [9:0] y,
                          input logic [2:0] c);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Pulse frame start, then watch four cycles; report edge pulses and ready just after the pulse.
  task automatic frame(output int n_edge, output int ready_first);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    ready_first = int'(ready);
    n_edge = 0;
    repeat (4) begin
      if (edge_o) n_edge++;
      tick();
    end
  endtask

  task automatic pixel(input logic [9:0] c, input logic [9:0] r);
    col = c; row = r;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check_value("rst_rgb", rgb, 0);
    check_value("rst_hit", hit, 0);
    check_value("rst_edge", edge_o, 0);
    check_value("rst_ready", ready, 1);
    rst_n = 1'b1;
    tick();
    check_value("idle_ready", ready, 1);
    check_value("idle_posx", pos_x, 0);
    check_value("idle_posy", pos_y, 0);

    // Basic pixel pipeline at position (0,0)
    enable = 1'b1; back = 3'b001; mask = 1'b1;
    pixel(10'd5, 10'd5);
    check_value("pix_in_rgb", rgb, 3'b111);
    check_value("pix_in_hit", hit, 1);
    pixel(10'd20, 10'd5);
    check_value("pix_out_rgb", rgb, 3'b001);
    check_value("pix_out_hit", hit, 0);
    pixel(10'd1023, 10'd0);
    check_value("pix_leftwrap_hit", hit, 0);

    // MOVE_ABS with X clamp
    mode = 2'd1;
    send_cmd(3'd1, 10'd700, 10'd100, 3'd0);
    check_value("pend_ready", ready, 0);
    frame(edges, rdy0);
    check_value("upd_ready", rdy0, 0);
    check_value("abs_posx", pos_x, 624);
    check_value("abs_posy", pos_y, 100);
    check_value("abs_ready_after", ready, 1);
    check_value("abs_edges", edges, 0);

    // Bounce on right edge
    mode = 2'd2;
    send_cmd(3'd1, 10'd620, 10'd100, 3'd0);
    frame(edges, rdy0);
    check_value("bnc_start", pos_x, 620);
    send_cmd(3'd3, 10'd8, 10'd0, 3'd0);
    frame(edges, rdy0);
    check_value("bnc_posx", pos_x, 620);
    check_value("bnc_edges", edges, 1);
    frame(edges, rdy0);
    check_value("bnc_next_posx", pos_x, 612);
    check_value("bnc_next_edges", edges, 0);
    send_cmd(3'd5, 10'd0, 10'd0, 3'd0);
    frame(edges, rdy0);
    check_value("stop_posx", pos_x, 612);

    // Wrap on left edge
    mode = 2'd0;
    send_cmd(3'd1, 10'd2, 10'd100, 3'd0);
    frame(edges, rdy0);
    send_cmd(3'd3, 10'h3FB, 10'd0, 3'd0);
    frame(edges, rdy0);
    check_value("wrap_posx", pos_x, 622);
    check_value("wrap_edges", edges, 1);
    send_cmd(3'd5, 10'd0, 10'd0, 3'd0);
    frame(edges, rdy0);

    // Clamp on bottom edge, then saturating relative move
    mode = 2'd1;
    send_cmd(3'd1, 10'd100, 10'd460, 3'd0);
    frame(edges, rdy0);
    send_cmd(3'd3, 10'd0, 10'd7, 3'd0);
    frame(edges, rdy0);
    check_value("clamp_posy", pos_y, 464);
    check_value("clamp_edges", edges, 1);
    frame(edges, rdy0);
    check_value("clamp_hold_posy", pos_y, 464);
    check_value("clamp_hold_edges", edges, 0);
    send_cmd(3'd2, 10'h338, 10'd0, 3'd0);
    frame(edges, rdy0);
    check_value("rel_sat_posx", pos_x, 0);
    check_value("rel_posy", pos_y, 464);

    // Command accepted together with frame start waits one frame
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_color = 3'b100; frame_start = 1'b1;
    tick();
    cmd_valid = 1'b0; frame_start = 1'b0;
    repeat (4) tick();
    check_value("same_cycle_ready", ready, 0);
    pixel(10'd3, 10'd466);
    check_value("color_unchanged", rgb, 3'b111);
    frame(edges, rdy0);
    pixel(10'd3, 10'd466);
    check_value("color_applied", rgb, 3'b100);

    // Reset while a command is pending
    send_cmd(3'd4, 10'd0, 10'd0, 3'b010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_value("rst_pend_ready", ready, 1);
    check_value("rst_pend_posy", pos_y, 0);
    frame(edges, rdy0);
    pixel(10'd5, 10'd5);
    check_value("rst_pend_color", rgb, 3'b111);

    // Boundary pixels and mask address at (100,50)
    send_cmd(3'd1, 10'd100, 10'd50, 3'd0);
    frame(edges, rdy0);
    pixel(10'd99, 10'd50);
    check_value("miss_left_hit", hit, 0);
    pixel(10'd116, 10'd50);
    check_value("miss_right_hit", hit, 0);
    pixel(10'd100, 10'd49);
    check_value("miss_top_hit", hit, 0);
    pixel(10'd115, 10'd65);
    check_value("corner_hit", hit, 1);
    mask = 1'b0;
    pixel(10'd110, 10'd55);
    check_value("transparent_hit", hit, 0);
    check_value("transparent_rgb", rgb, 3'b001);
    col = 10'd103; row = 10'd52;
    #1;
    check_value("mask_addr", mask_addr, 8'h23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
Parametrised successor to the fixed 16x16 sprite. Adds configurable sprite and screen size, and a valid/ready command port whose updates are applied only at frame start, so there is no tearing. Adds per-frame velocity motion with selectable edge mode (wrap/clamp/bounce) and a 2-stage pixel pipeline driving an external synchronous mask ROM. Sits between the VGA timing counters and the pixel mux, one instance per sprite.

Parameters:
SPR_W, 16, sprite width in pixels (power of two, >=2)
SPR_H, 16, sprite height in pixels (power of two, >=2)
POS_W, 10, width of counters and positions
COLOR_W, 3, colour width
SCREEN_W, 640, visible columns
SCREEN_H, 480, visible rows
VEL_W, 5, signed per-frame velocity width
RESET_COLOR, 3'b111, sprite colour after reset

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low reset
iColumnCount  input  POS_W  current pixel column
iRowCount  input  POS_W  current pixel row
iFrameStart  input  1  one-cycle pulse at start of vertical blank
iEnable  input  1  sprite visible
iColorBack  input  COLOR_W  background colour
iMode  input  2  edge mode: 0 wrap, 1 clamp, 2 bounce, 3 = clamp
iCmdValid  input  1  command valid
oCmdReady  output  1  command slot free
iCmdOp  input  3  0 NOP, 1 MOVE_ABS, 2 MOVE_REL, 3 SET_VEL, 4 SET_COLOR, 5 STOP; 6-7 = NOP
iCmdX  input  POS_W  X operand (unsigned for ABS; signed for REL/VEL, low VEL_W bits for VEL)
iCmdY  input  POS_W  Y operand, same rules
iCmdColor  input  COLOR_W  colour operand
oMaskAddr  output  log2(SPR_W*SPR_H)  mask ROM address, {dy, dx}
iMask  input  1  ROM data, valid one cycle after oMaskAddr
oRGB  output  COLOR_W  pixel colour
oHit  output  1  opaque sprite pixel drawn this cycle
oEdge  output  1  one-cycle pulse: motion crossed an edge
oPosX  output  POS_W  current X
oPosY  output  POS_W  current Y

Behaviour:
- Reset (async, low): PosX=PosY=0, VelX=VelY=0, colour=RESET_COLOR, pending slot empty, FSM IDLE. oRGB=0, oHit=0, oEdge=0, oCmdReady=1, pipeline regs cleared. Reset mid-update drops any pending command.
- MAXX=SCREEN_W-SPR_W; MAXY=SCREEN_H-SPR_H. Positions always stay in [0,MAX].
- FSM states:
  - IDLE: oCmdReady=1. iCmdValid captures the op and operands into the pending slot and moves to PEND. iFrameStart moves to UPD_MOT.
  - PEND: oCmdReady=0. iFrameStart moves to UPD_CMD.
  - UPD_CMD: applies the pending command (one cycle), then goes to UPD_MOT.
  - UPD_MOT: pos += vel per axis with edge handling; sets oEdge if any axis hit an edge; then returns to IDLE.
- A command accepted in the same cycle as iFrameStart (in IDLE) goes to PEND. It is applied at the next frame start; this frame runs motion only.
- iFrameStart is ignored in UPD_CMD and UPD_MOT.
- Command semantics:
  - MOVE_ABS: pos = min(operand, MAX).
  - MOVE_REL: pos + sign-extended operand, saturated to [0,MAX] regardless of mode; velocity unchanged.
  - SET_VEL: vel = operand[VEL_W-1:0].
  - STOP: vel = 0.
  - SET_COLOR: colour = iCmdColor.
- Edge step per axis (n = pos + sext(vel), computed at POS_W+2 bits signed):
  - wrap: n<0 gives n+MAX+1; n>MAX gives n-(MAX+1).
  - clamp: saturate to 0 or MAX and set that velocity component to 0.
  - bounce: n<0 gives -n; n>MAX gives 2*MAX-n; that velocity component is negated.
  - Any of these cases sets oEdge.
  - |vel| <= MAX is guaranteed by parameter choice.
- Pixel pipeline, counts sampled in cycle t:
  - Cycle t (combinational): dx=col-PosX, dy=row-PosY. inside = iEnable && dx<SPR_W && dy<SPR_H, using unsigned wrap so left/top misses are excluded. oMaskAddr={dy[log2H-1:0],dx[log2W-1:0]}.
  - Edge t→t+1: register inside, colour, iColorBack.
  - Edge t+1→t+2: oRGB = (inside_q && iMask) ? colour_q : back_q; oHit = inside_q && iMask.
  - Total latency 2 cycles. Position changes only in vblank, so there is no mid-frame tear.

Decomposition:
- sprite_pkg: opcode constants, mode constants, FSM state encoding, clog2 helper for address width.
- Sub-module sprite_edge_step, instantiated twice (X, Y):
  - Inputs: pos, vel, max, mode.
  - Outputs: next pos, next vel, edge flag.
  - Purely combinational; registers stay in sprite_engine.
- The mask ROM remains external.

Test Plan:
- Reset then idle: oRGB=0, oCmdReady=1, oPosX=oPosY=0. Drive col=row=5 with iMask=1, iEnable=1, iColorBack=3'b001 → oRGB=3'b111 two cycles later, oHit=1. At col=20 → oRGB=3'b001.
- MOVE_ABS X=700,Y=100 accepted, then iFrameStart → oCmdReady=0 until the update. Afterwards oPosX=624 (clamped), oPosY=100, oCmdReady=1.
- Bounce mode, pos X=620, SET_VEL X=+8 applied → at the next frame oPosX=620, vel X=-8, oEdge pulses once. The following frame gives oPosX=612 with no edge.
- Wrap mode, X=2, vel X=-5 → oPosX=622, oEdge=1. Clamp mode, Y=460, vel Y=+7 → oPosY=464, vel Y=0, later frames stay at 464.
- iCmdValid (SET_COLOR 3'b100) in the same cycle as iFrameStart → colour unchanged this frame, 3'b100 after the next iFrameStart. Reset asserted while in PEND → pending command lost, colour = RESET_COLOR.
- Pixel at col=PosX-1 (wrap to 1023) and col=PosX+16 → oHit=0. oMaskAddr at col=PosX+3, row=PosY+2 → 8'h23.
